// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_edge filter.
// The state encoding is fixed at 2 bits so the FSM register stays minimal.
package debounce_pkg;

  localparam int unsigned RunCntWidth = 8;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    CHECK_HIGH  = 2'b01,
    STABLE_HIGH = 2'b10,
    CHECK_LOW   = 2'b11
  } db_state_e;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear; wraps to 1 after reaching rollover_val.
// rollover_flag is high while the count equals rollover_val.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = NUM_CNT_BITS'(1);
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/debounce_edge.sv
// Debounce filter for an already-synchronized level: accepts a new value after
// DEBOUNCE_CYCLES consecutive samples, flags aborted candidates, counts edges.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sync_in,
  input  logic                 enable,
  input  logic                 clear_count,
  output logic                 stable_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic                 glitch,
  output logic [CNT_WIDTH-1:0] edge_count
);

  db_state_e state_q, state_d;

  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   glitch_q, glitch_d;
  logic [CNT_WIDTH-1:0]   edge_cnt_q, edge_cnt_d;

  logic                   run_clear, run_en, run_flag, run_done;
  logic [RunCntWidth-1:0] run_cnt;

  flex_counter #(
    .NUM_CNT_BITS(RunCntWidth)
  ) u_run_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (run_clear),
    .count_enable (run_en),
    .rollover_val (RunCntWidth'(DEBOUNCE_CYCLES - 1)),
    .count_out    (run_cnt),
    .rollover_flag(run_flag)
  );

  // A zero run count never completes a check; count is >= 1 in both check states.
  assign run_done = run_flag && (run_cnt != '0);

  // State register (plus registered outputs).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= STABLE_LOW;
      stable_q   <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      glitch_q   <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stable_q   <= stable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      glitch_q   <= glitch_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        STABLE_LOW:  if (sync_in)  state_d = CHECK_HIGH;
        CHECK_HIGH: begin
          if (!sync_in)      state_d = STABLE_LOW;
          else if (run_done) state_d = STABLE_HIGH;
        end
        STABLE_HIGH: if (!sync_in) state_d = CHECK_LOW;
        CHECK_LOW: begin
          if (sync_in)       state_d = STABLE_HIGH;
          else if (run_done) state_d = STABLE_LOW;
        end
        default: state_d = STABLE_LOW;
      endcase
    end
  end

  // Output and run-counter control logic.
  always_comb begin
    run_clear = 1'b0;
    run_en    = 1'b0;
    stable_d  = stable_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    glitch_d  = 1'b0;
    if (enable) begin
      unique case (state_q)
        STABLE_LOW: begin
          run_en    = sync_in;
          run_clear = !sync_in;
        end
        CHECK_HIGH: begin
          if (!sync_in) begin
            run_clear = 1'b1;
            glitch_d  = 1'b1;
          end else if (run_done) begin
            run_clear = 1'b1;
            stable_d  = 1'b1;
            rise_d    = 1'b1;
          end else begin
            run_en = 1'b1;
          end
        end
        STABLE_HIGH: begin
          run_en    = !sync_in;
          run_clear = sync_in;
        end
        CHECK_LOW: begin
          if (sync_in) begin
            run_clear = 1'b1;
            glitch_d  = 1'b1;
          end else if (run_done) begin
            run_clear = 1'b1;
            stable_d  = 1'b0;
            fall_d    = 1'b1;
          end else begin
            run_en = 1'b1;
          end
        end
        default: run_clear = 1'b1;
      endcase
    end

    // Clear wins over a coincident increment and works even while frozen.
    if (clear_count) begin
      edge_cnt_d = '0;
    end else if (rise_d || fall_d) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end else begin
      edge_cnt_d = edge_cnt_q;
    end
  end

  assign stable_out = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign glitch     = glitch_q;
  assign edge_count = edge_cnt_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge with DEBOUNCE_CYCLES=4, CNT_WIDTH=8.
module tb_debounce_edge;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       sync_in;
  logic       enable;
  logic       clear_count;
  logic       stable_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       glitch;
  logic [7:0] edge_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  debounce_edge #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (8)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sync_in    (sync_in),
    .enable     (enable),
    .clear_count(clear_count),
    .stable_out (stable_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .glitch     (glitch),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic s, input logic r, input logic f,
                           input logic g, input int c);
    check({tag, ".stable"}, {31'b0, stable_out}, {31'b0, s});
    check({tag, ".rise"}, {31'b0, rise_pulse}, {31'b0, r});
    check({tag, ".fall"}, {31'b0, fall_pulse}, {31'b0, f});
    check({tag, ".glitch"}, {31'b0, glitch}, {31'b0, g});
    check({tag, ".count"}, {24'b0, edge_count}, c % 256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset held with sync_in high.
    n_rst       = 1'b0;
    sync_in     = 1'b1;
    enable      = 1'b1;
    clear_count = 1'b0;
    repeat (3) tick();
    check_all("rst_hold", 0, 0, 0, 0, 0);
    sync_in = 1'b0;
    #2 n_rst = 1'b1;
    tick();
    check_all("rst_rel", 0, 0, 0, 0, 0);

    // 2. Clean rise: accepted on the 4th sampling edge.
    sync_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_all($sformatf("rise_e%0d", i), 0, 0, 0, 0, 0);
    end
    tick();
    exp_cnt = 1;
    check_all("rise_e4", 1, 1, 0, 0, exp_cnt);
    tick();
    check_all("rise_e5", 1, 0, 0, 0, exp_cnt);
    tick();
    check_all("rise_e6", 1, 0, 0, 0, exp_cnt);

    // 4. Clean fall.
    sync_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_all($sformatf("fall_e%0d", i), 1, 0, 0, 0, exp_cnt);
    end
    tick();
    exp_cnt = 2;
    check_all("fall_e4", 0, 0, 1, 0, exp_cnt);
    tick();
    check_all("fall_e5", 0, 0, 0, 0, exp_cnt);

    // 3. Glitch: two high samples then low.
    sync_in = 1'b1;
    tick();
    tick();
    check_all("gl_e2", 0, 0, 0, 0, exp_cnt);
    sync_in = 1'b0;
    tick();
    check_all("gl_abort", 0, 0, 0, 1, exp_cnt);
    tick();
    check_all("gl_after", 0, 0, 0, 0, exp_cnt);

    // 5. Freeze after two high samples; rise needs two more edges.
    sync_in = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_all("frz_hold", 0, 0, 0, 0, exp_cnt);
    enable = 1'b1;
    tick();
    check_all("frz_e3", 0, 0, 0, 0, exp_cnt);
    tick();
    exp_cnt = 3;
    check_all("frz_e4", 1, 1, 0, 0, exp_cnt);

    // 6. Wrap edge_count: 253 more transitions reach 256 -> 0.
    for (int i = 0; i < 253; i++) begin
      sync_in = ~sync_in;
      repeat (4) tick();
      exp_cnt = exp_cnt + 1;
      check($sformatf("wrap_%0d", i), {24'b0, edge_count}, exp_cnt % 256);
    end
    check("wrap_zero", {24'b0, edge_count}, 0);
    check("wrap_level", {31'b0, stable_out}, 0);

    // Clear coincident with a rise pulse wins.
    sync_in = 1'b1;
    repeat (3) tick();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check_all("clr_rise", 1, 1, 0, 0, 0);

    // Clear honoured while frozen.
    sync_in = 1'b0;
    repeat (4) tick();
    check_all("clr_pre", 0, 0, 1, 0, 1);
    enable      = 1'b0;
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check_all("clr_frozen", 0, 0, 0, 0, 0);
    enable = 1'b1;

    // Reset mid-check discards the pending candidate.
    sync_in = 1'b1;
    tick();
    tick();
    #2 n_rst = 1'b0;
    #1;
    check_all("mid_rst", 0, 0, 0, 0, 0);
    tick();
    n_rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("mid_rise_e%0d", i), {31'b0, rise_pulse}, 0);
    end
    tick();
    check_all("mid_rise_e4", 1, 1, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Stage directly downstream of the two-flop low-reset synchronizer; consumes its sync_out as sync_in.
- Filters bounce or glitches on the synchronized signal. Produces a debounced level, single-cycle rise and fall pulses, a one-cycle glitch flag, and a running edge counter for the control logic further downstream.
- Purely synchronous to clk; no metastability handling inside, since the input is already synchronized.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clk edges sync_in must hold a new value before it is accepted; legal range 2..255.
- CNT_WIDTH, 8: width of edge_count.

Ports:
- clk  input  1  system clock, rising-edge active.
- n_rst  input  1  reset; one clock; reset is asynchronous and active-low.
- sync_in  input  1  synchronized input (sync_out of the synchronizer stage).
- enable  input  1  1 = filter runs; 0 = freeze all state, pulses forced 0.
- clear_count  input  1  synchronous clear of edge_count.
- stable_out  output  1  debounced level, registered.
- rise_pulse  output  1  one-cycle pulse on an accepted 0->1 transition, registered.
- fall_pulse  output  1  one-cycle pulse on an accepted 1->0 transition, registered.
- glitch  output  1  one-cycle pulse when a candidate transition is aborted, registered.
- edge_count  output  CNT_WIDTH  number of accepted transitions (rise + fall), modulo 2^CNT_WIDTH.

Behaviour:
- Reset (n_rst=0, async):
  - State STABLE_LOW; run counter 0.
  - stable_out=0, which matches the synchronizer reset value.
  - rise_pulse, fall_pulse and glitch = 0; edge_count=0.
  - Reset asserted mid-check discards the pending candidate immediately.
- FSM states: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW; the run counter is 8 bits.
- STABLE_LOW:
  - sync_in=1 -> CHECK_HIGH, cnt=1.
  - Otherwise stay, cnt=0.
- CHECK_HIGH, with sync_in=1:
  - cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, cnt=0, stable_out<=1, rise_pulse<=1.
  - Otherwise cnt<=cnt+1.
- CHECK_HIGH, with sync_in=0:
  - -> STABLE_LOW, cnt=0, glitch<=1; stable_out unchanged.
- STABLE_HIGH and CHECK_LOW mirror the two states above with opposite polarity; acceptance gives stable_out<=0 and fall_pulse<=1.
- Latency:
  - stable_out changes on the DEBOUNCE_CYCLES-th consecutive clk edge at which sync_in is sampled at the new value.
  - Total latency from async input = 2 (synchronizer) + DEBOUNCE_CYCLES edges.
- Pulse timing:
  - Each pulse is high exactly one cycle and is coincident with the stable_out change (rise/fall) or with the abort (glitch).
  - At most one of rise_pulse, fall_pulse, glitch is high in any cycle.
- enable=0:
  - State, cnt, stable_out and edge_count hold.
  - rise_pulse, fall_pulse and glitch are driven 0 on the next edge.
  - clear_count is still honoured.
- edge_count:
  - Increments by 1 on each edge where rise_pulse or fall_pulse is set.
  - Wraps from 2^CNT_WIDTH-1 to 0.
  - clear_count has priority over a simultaneous increment; the result is 0.
- sync_in at X: treated as not equal to the current stable value (the bench must not rely on this beyond the synchronizer guaranteeing 0/1).

Decomposition:
- Shared package debounce_pkg holds:
  - the state enum type (STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW), 2-bit encoding;
  - the run-counter width constant, 8.
- One sub-module, flex_counter: NUM_CNT_BITS parameter; ports clear, count_enable, rollover_val, count_out, rollover_flag. It is used for the run counter.
- edge_count stays inline as a plain register.

Test Plan (all with DEBOUNCE_CYCLES=4, CNT_WIDTH=8):
1. Reset: assert n_rst=0 with sync_in=1 held for 3 clocks -> stable_out=0, edge_count=0, all pulses 0; release reset off-edge, still 0.
2. Clean rise: sync_in 0->1 held 6 clocks -> stable_out=1 exactly at the 4th sampling edge, rise_pulse high that one cycle, edge_count=1.
3. Glitch: sync_in=1 for 2 clocks, then 0 -> glitch pulses one cycle, stable_out stays 0, edge_count unchanged, no rise_pulse.
4. Clean fall after test 2: sync_in=0 held 4 clocks -> stable_out=0, fall_pulse one cycle, edge_count=2.
5. Enable freeze: enable=0 after 2 high samples for 5 clocks, then enable=1 with sync_in still 1 -> rise occurs after 2 more edges.
6. Counter: 256 accepted transitions wrap edge_count to 0; clear_count asserted in the same cycle as a rise_pulse -> edge_count=0.
